// File: rtl/calc_mode_sequencer.sv
// UI mode sequencer: main -> graph menu -> coefficient input -> plot compute -> graphing, with screen/button routing.
// Latency: every mode change is registered (pulse in cycle n -> new state, state_entry, plot_start in n+1).
// No backpressure: all inputs are one-cycle pulses; plot_start/plot_done form a request/done handshake.
module calc_mode_sequencer #(
    parameter int                PIX_W          = 16,
    parameter int                ZOOM_MAX       = 7,
    parameter int                PAN_STEP       = 4,
    parameter int                PAN_LIMIT      = 64,
    parameter int                TIMEOUT_CYCLES = 625000000,
    parameter logic [PIX_W-1:0]  BUSY_COLOR     = PIX_W'(16'hFFE0)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           btn,
    input  logic                 menu_confirmed,
    input  logic                 all_inputs_confirmed,
    input  logic                 plot_done,
    input  logic [4*PIX_W-1:0]   s1_src,
    input  logic [4*PIX_W-1:0]   s2_src,
    output logic [2:0]           state,
    output logic                 state_entry,
    output logic [4:0]           btn_menu,
    output logic [4:0]           btn_input,
    output logic                 keypad_enable,
    output logic                 plot_start,
    output logic [2:0]           zoom_level,
    output logic [7:0]           pan_x,
    output logic [PIX_W-1:0]     screen1_data,
    output logic [PIX_W-1:0]     screen2_data
);

    typedef enum logic [2:0] {
        S_MAIN    = 3'd0,
        S_MENU    = 3'd1,
        S_INPUT   = 3'd2,
        S_COMPUTE = 3'd3,
        S_GRAPH   = 3'd4
    } mode_t;

    // A zero timeout still needs a legal 1-bit counter; it is simply held at 0.
    localparam int                TW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0]     T_LAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [2:0]        ZMAX   = 3'(ZOOM_MAX);
    localparam logic signed [9:0] STEP   = 10'(PAN_STEP);
    localparam logic signed [9:0] LIMIT  = 10'(PAN_LIMIT);

    mode_t             mode_q;
    mode_t             mode_d;
    logic [TW-1:0]     timer_q;
    logic [2:0]        zoom_d;
    logic [7:0]        pan_d;
    logic signed [9:0] pan_ext;
    logic signed [9:0] pan_dn;
    logic signed [9:0] pan_up;
    logic              idle_mode;
    logic              timer_clr;
    logic              b_u, b_d, b_l, b_r, b_c;

    assign {b_u, b_d, b_l, b_r, b_c} = btn;
    assign state = mode_q;

    // Only MENU, INPUT and GRAPH are subject to the inactivity timeout.
    assign idle_mode = (mode_q == S_MENU) || (mode_q == S_INPUT) || (mode_q == S_GRAPH);

    // Next-mode and next-view decode; timeout only applies when nothing else moves the FSM.
    always_comb begin
        mode_d  = mode_q;
        zoom_d  = zoom_level;
        pan_d   = pan_x;
        pan_ext = {{2{pan_x[7]}}, pan_x};
        pan_dn  = pan_ext - STEP;
        if (pan_dn < -LIMIT) pan_dn = -LIMIT;
        pan_up  = pan_ext + STEP;
        if (pan_up > LIMIT) pan_up = LIMIT;

        case (mode_q)
            S_MAIN:    if (|btn) mode_d = S_MENU;
            S_MENU:    if (menu_confirmed) mode_d = S_INPUT;
            S_INPUT:   if (all_inputs_confirmed) mode_d = S_COMPUTE;
            S_COMPUTE: if (plot_done) mode_d = S_GRAPH;
            S_GRAPH: begin
                // Only the highest-priority pressed button acts: D > U > C > L > R.
                if (b_d) begin
                    mode_d = S_MENU;
                end else if (b_u) begin
                    if (zoom_level < ZMAX) zoom_d = zoom_level + 3'd1;
                end else if (b_c) begin
                    if (zoom_level != 3'd0) zoom_d = zoom_level - 3'd1;
                end else if (b_l) begin
                    pan_d = pan_dn[7:0];
                end else if (b_r) begin
                    pan_d = pan_up[7:0];
                end
                // A view change needs fresh samples; a saturated press leaves the plot as is.
                if (!b_d && ((zoom_d != zoom_level) || (pan_d != pan_x))) mode_d = S_COMPUTE;
            end
            default:   mode_d = S_MAIN;
        endcase

        if ((TIMEOUT_CYCLES != 0) && idle_mode && (mode_d == mode_q) &&
            (btn == 5'd0) && (timer_q == T_LAST)) begin
            mode_d = S_MAIN;
        end
    end

    assign timer_clr = (|btn) || (mode_d != mode_q) ||
                       (mode_q == S_MAIN) || (mode_q == S_COMPUTE);

    // Mode register, registered status outputs, view registers and idle timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q        <= S_MAIN;
            state_entry   <= 1'b0;
            plot_start    <= 1'b0;
            keypad_enable <= 1'b0;
            zoom_level    <= 3'd0;
            pan_x         <= 8'd0;
            timer_q       <= '0;
        end else begin
            mode_q        <= mode_d;
            state_entry   <= (mode_d != mode_q);
            plot_start    <= (mode_d == S_COMPUTE) && (mode_q != S_COMPUTE);
            keypad_enable <= (mode_q == S_INPUT);
            if ((mode_d == S_MENU) && (mode_q != S_MENU)) begin
                zoom_level <= 3'd0;
                pan_x      <= 8'd0;
            end else begin
                zoom_level <= zoom_d;
                pan_x      <= pan_d;
            end
            if (timer_clr || (TIMEOUT_CYCLES == 0)) timer_q <= '0;
            else                                     timer_q <= timer_q + TW'(1);
        end
    end

    // Button routing to the block owning the current mode.
    always_comb begin
        btn_menu  = (mode_q == S_MENU)  ? btn : 5'd0;
        btn_input = (mode_q == S_INPUT) ? btn : 5'd0;
    end

    // Screen source select; COMPUTE shows a busy fill on screen 1 and keeps the graph on screen 2.
    always_comb begin
        screen1_data = s1_src[PIX_W-1:0];
        screen2_data = s2_src[PIX_W-1:0];
        case (mode_q)
            S_MENU: begin
                screen1_data = s1_src[2*PIX_W-1:PIX_W];
                screen2_data = s2_src[2*PIX_W-1:PIX_W];
            end
            S_INPUT: begin
                screen1_data = s1_src[3*PIX_W-1:2*PIX_W];
                screen2_data = s2_src[3*PIX_W-1:2*PIX_W];
            end
            S_COMPUTE: begin
                screen1_data = BUSY_COLOR;
                screen2_data = s2_src[4*PIX_W-1:3*PIX_W];
            end
            S_GRAPH: begin
                screen1_data = s1_src[4*PIX_W-1:3*PIX_W];
                screen2_data = s2_src[4*PIX_W-1:3*PIX_W];
            end
            default: begin
                screen1_data = s1_src[PIX_W-1:0];
                screen2_data = s2_src[PIX_W-1:0];
            end
        endcase
    end

endmodule

// File: tb/tb_calc_mode_sequencer.sv
// Directed bench for calc_mode_sequencer with a short idle timeout.
// Latency: checks are taken 1ns after each rising edge.
// No backpressure: stimulus is one-cycle pulses driven between edges.
module tb_calc_mode_sequencer;

    localparam int PW = 16;
    localparam int TO = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [4:0]      btn = 5'd0;
    logic            menu_confirmed = 1'b0;
    logic            all_inputs_confirmed = 1'b0;
    logic            plot_done = 1'b0;
    logic [4*PW-1:0] s1_src = {16'h1444, 16'h1333, 16'h1222, 16'h1111};
    logic [4*PW-1:0] s2_src = {16'h2444, 16'h2333, 16'h2222, 16'h2111};
    logic [2:0]      state;
    logic            state_entry;
    logic [4:0]      btn_menu;
    logic [4:0]      btn_input;
    logic            keypad_enable;
    logic            plot_start;
    logic [2:0]      zoom_level;
    logic [7:0]      pan_x;
    logic [PW-1:0]   screen1_data;
    logic [PW-1:0]   screen2_data;

    int ntests = 0;
    int nfail  = 0;

    calc_mode_sequencer #(
        .PIX_W(PW), .ZOOM_MAX(7), .PAN_STEP(4), .PAN_LIMIT(64),
        .TIMEOUT_CYCLES(TO), .BUSY_COLOR(16'hFFE0)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn),
        .menu_confirmed(menu_confirmed), .all_inputs_confirmed(all_inputs_confirmed),
        .plot_done(plot_done), .s1_src(s1_src), .s2_src(s2_src),
        .state(state), .state_entry(state_entry), .btn_menu(btn_menu), .btn_input(btn_input),
        .keypad_enable(keypad_enable), .plot_start(plot_start), .zoom_level(zoom_level),
        .pan_x(pan_x), .screen1_data(screen1_data), .screen2_data(screen2_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int         ez;
        int         ep;
        logic [7:0] pe;

        // Reset state
        #1 reset = 1'b0;
        tick(); tick();
        check("rst_state",  32'(state), 0);
        check("rst_entry",  32'(state_entry), 0);
        check("rst_keypad", 32'(keypad_enable), 0);
        check("rst_pstart", 32'(plot_start), 0);
        check("rst_zoom",   32'(zoom_level), 0);
        check("rst_pan",    32'(pan_x), 0);
        check("rst_scr1",   32'(screen1_data), 32'h1111);
        check("rst_scr2",   32'(screen2_data), 32'h2111);
        reset = 1'b1;
        tick();
        check("main_hold", 32'(state), 0);

        // MAIN -> MENU on a button
        btn = 5'b00001; #1;
        check("btn_menu_trig", 32'(btn_menu), 0);
        tick(); btn = 5'd0;
        check("menu_state", 32'(state), 1);
        check("menu_entry", 32'(state_entry), 1);
        check("menu_scr1",  32'(screen1_data), 32'h1222);
        tick();
        check("menu_entry_drop", 32'(state_entry), 0);
        btn = 5'b00100; #1;
        check("btn_menu_route", 32'(btn_menu), 5'b00100);
        check("btn_input_gate", 32'(btn_input), 0);
        btn = 5'd0;

        // MENU -> INPUT, keypad_enable lags by one cycle
        menu_confirmed = 1'b1; tick(); menu_confirmed = 1'b0;
        check("input_state", 32'(state), 2);
        check("keypad_lag",  32'(keypad_enable), 0);
        tick();
        check("keypad_on",   32'(keypad_enable), 1);
        btn = 5'b00010; #1;
        check("btn_input_route", 32'(btn_input), 5'b00010);
        check("btn_menu_gate",   32'(btn_menu), 0);
        btn = 5'd0;

        // INPUT -> COMPUTE, plot_start one cycle, no timeout while computing
        all_inputs_confirmed = 1'b1; tick(); all_inputs_confirmed = 1'b0;
        check("compute_state",  32'(state), 3);
        check("compute_pstart", 32'(plot_start), 1);
        check("compute_scr2",   32'(screen2_data), 32'h2444);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("compute_busy", 32'(screen1_data), 32'hFFE0);
            check("compute_stay", 32'(state), 3);
        end
        check("pstart_drop", 32'(plot_start), 0);

        plot_done = 1'b1; tick(); plot_done = 1'b0;
        check("graph_state", 32'(state), 4);
        check("graph_entry", 32'(state_entry), 1);
        check("graph_scr1",  32'(screen1_data), 32'h1444);

        // Zoom in 9 times; plot_done arrives in the COMPUTE entry cycle each time
        for (int i = 0; i < 9; i++) begin
            btn = 5'b10000; tick(); btn = 5'd0;
            ez = (i < 7) ? i + 1 : 7;
            check("zoom_u", 32'(zoom_level), ez);
            if (i < 7) begin
                check("zoom_replot", 32'(state), 3);
                check("zoom_pstart", 32'(plot_start), 1);
                plot_done = 1'b1; tick(); plot_done = 1'b0;
                check("zoom_back", 32'(state), 4);
            end else begin
                check("zoom_sat_stay", 32'(state), 4);
            end
        end

        // Zoom out once
        btn = 5'b00001; tick(); btn = 5'd0;
        check("zoom_c", 32'(zoom_level), 6);
        check("zoom_c_replot", 32'(state), 3);
        plot_done = 1'b1; tick(); plot_done = 1'b0;

        // Pan left 20 times, saturating at -64
        for (int i = 0; i < 20; i++) begin
            btn = 5'b00100; tick(); btn = 5'd0;
            ep = -4 * (i + 1);
            if (ep < -64) ep = -64;
            pe = ep[7:0];
            check("pan_l", 32'(pan_x), 32'(pe));
            if (i < 16) begin
                check("pan_replot", 32'(state), 3);
                plot_done = 1'b1; tick(); plot_done = 1'b0;
            end else begin
                check("pan_sat_stay", 32'(state), 4);
            end
        end
        check("pan_min", 32'(pan_x), 32'hC0);

        // Pan right once from the limit
        btn = 5'b00010; tick(); btn = 5'd0;
        check("pan_r", 32'(pan_x), 32'hC4);
        plot_done = 1'b1; tick(); plot_done = 1'b0;

        // Priority: U beats C
        btn = 5'b10001; tick(); btn = 5'd0;
        check("prio_uc_zoom", 32'(zoom_level), 7);
        check("prio_uc_state", 32'(state), 3);
        plot_done = 1'b1; tick(); plot_done = 1'b0;

        // Priority: D beats U, view clears on MENU entry
        btn = 5'b11000; tick(); btn = 5'd0;
        check("prio_ud_state", 32'(state), 1);
        check("prio_ud_entry", 32'(state_entry), 1);
        check("menu_zoom_clr", 32'(zoom_level), 0);
        check("menu_pan_clr",  32'(pan_x), 0);

        // plot_done ignored outside COMPUTE
        plot_done = 1'b1; tick(); plot_done = 1'b0;
        check("pd_ignored_menu", 32'(state), 1);

        // Idle in INPUT times out after exactly TO cycles
        menu_confirmed = 1'b1; tick(); menu_confirmed = 1'b0;
        check("to1_input", 32'(state), 2);
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            check("to1_hold", 32'(state), 2);
        end
        tick();
        check("to1_main",  32'(state), 0);
        check("to1_entry", 32'(state_entry), 1);

        // A press in the expiry cycle restarts the count
        btn = 5'b00001; tick(); btn = 5'd0;
        menu_confirmed = 1'b1; tick(); menu_confirmed = 1'b0;
        check("to2_input", 32'(state), 2);
        repeat (TO - 1) tick();
        btn = 5'b00001; tick(); btn = 5'd0;
        check("to2_restart", 32'(state), 2);
        repeat (TO - 1) tick();
        check("to2_hold", 32'(state), 2);
        tick();
        check("to2_main", 32'(state), 0);

        // Transition pulse in the expiry cycle wins
        btn = 5'b00001; tick(); btn = 5'd0;
        menu_confirmed = 1'b1; tick(); menu_confirmed = 1'b0;
        repeat (TO - 1) tick();
        all_inputs_confirmed = 1'b1; tick(); all_inputs_confirmed = 1'b0;
        check("to3_compute", 32'(state), 3);
        check("to3_pstart",  32'(plot_start), 1);

        // Asynchronous reset while plot_start is high
        #2 reset = 1'b0;
        #1;
        check("arst_pstart", 32'(plot_start), 0);
        check("arst_state",  32'(state), 0);
        tick();
        reset = 1'b1;
        plot_done = 1'b1; tick(); plot_done = 1'b0;
        check("arst_pd_state",  32'(state), 0);
        check("arst_pd_pstart", 32'(plot_start), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
